// File: rtl/wave_gen_multi.sv
// wave_gen_multi: multi-shape waveform generator (triangle, saw-up, square,
// saw-down) built around one WIDTH-bit phase counter and a triangle
// direction flag. The dac_out sample is registered, so it follows the
// inputs by one clock.
//
// Optional feature: define WAVE_GEN_WRAP_PULSE_EN to enable the
// period-boundary strobe on wrap_pulse. When the macro is not defined,
// wrap_pulse is tied to 0 and no boundary logic is built.
//
// WIDTH is meant to lie between 4 and 16.
module wave_gen_multi #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] phase,
  input  logic             load,
  output logic [WIDTH-1:0] dac_out,
  output logic             dir,
  output logic             wrap_pulse
);

  typedef enum logic [1:0] {
    MODE_TRI    = 2'b00,
    MODE_SAW_UP = 2'b01,
    MODE_SQUARE = 2'b10,
    MODE_SAW_DN = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  // Map a counter value to the output sample for the selected shape.
  // Square is a full-scale level set by the counter MSB. Every other
  // shape outputs the counter unchanged.
  function automatic logic [WIDTH-1:0] shape_sample(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] c
  );
    logic [WIDTH-1:0] s;
    case (mode_t'(m))
      MODE_SQUARE: s = c[WIDTH-1] ? MAX_VAL : ZERO_VAL;
      MODE_TRI,
      MODE_SAW_UP,
      MODE_SAW_DN: s = c;
      default:     s = c;
    endcase
    return s;
  endfunction

  logic [WIDTH-1:0] counter_r;
  logic             dir_r;
  logic [WIDTH-1:0] counter_nxt_s;
  logic             dir_nxt_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] headroom_s;

  assign sum_s      = counter_r + step;
  assign diff_s     = counter_r - step;
  assign headroom_s = MAX_VAL - counter_r;
  assign dir        = dir_r;

  // Compute the next counter and direction for one enabled advance.
  always_comb begin
    counter_nxt_s = counter_r;
    dir_nxt_s     = dir_r;
    if (step == ZERO_VAL) begin
      // A zero step freezes the generator, including triangle turnarounds.
      counter_nxt_s = counter_r;
      dir_nxt_s     = dir_r;
    end else begin
      case (mode_t'(mode))
        MODE_TRI: begin
          if (dir_r) begin
            if (counter_r == MAX_VAL) begin
              // Turn around at the top. The step never exceeds MAX,
              // so this result cannot go below zero.
              dir_nxt_s     = 1'b0;
              counter_nxt_s = MAX_VAL - step;
            end else if (headroom_s < step) begin
              counter_nxt_s = MAX_VAL;
            end else begin
              counter_nxt_s = sum_s;
            end
          end else begin
            if (counter_r == ZERO_VAL) begin
              // Turn around at the bottom. The step never exceeds MAX.
              dir_nxt_s     = 1'b1;
              counter_nxt_s = step;
            end else if (counter_r < step) begin
              counter_nxt_s = ZERO_VAL;
            end else begin
              counter_nxt_s = diff_s;
            end
          end
        end
        MODE_SAW_UP,
        MODE_SQUARE: begin
          counter_nxt_s = sum_s;
        end
        MODE_SAW_DN: begin
          counter_nxt_s = diff_s;
        end
        default: begin
          counter_nxt_s = counter_r;
        end
      endcase
    end
  end

  // State and sample register: reset and load restart from phase;
  // otherwise the state advances only while en is high.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      counter_r <= phase;
      dir_r     <= 1'b1;
      dac_out   <= shape_sample(mode, phase);
    end else if (en) begin
      counter_r <= counter_nxt_s;
      dir_r     <= dir_nxt_s;
      dac_out   <= shape_sample(mode, counter_nxt_s);
    end else begin
      counter_r <= counter_r;
      dir_r     <= dir_r;
      dac_out   <= dac_out;
    end
  end

`ifdef WAVE_GEN_WRAP_PULSE_EN
  logic [WIDTH:0] carry_sum_s;
  logic           boundary_s;

  assign carry_sum_s = {1'b0, counter_r} + {1'b0, step};

  // Detect a period boundary on the advance that is about to happen.
  always_comb begin
    boundary_s = 1'b0;
    if (step == ZERO_VAL) begin
      boundary_s = 1'b0;
    end else begin
      case (mode_t'(mode))
        MODE_TRI:    boundary_s = ~dir_r && (counter_r == ZERO_VAL);
        MODE_SAW_UP,
        MODE_SQUARE: boundary_s = carry_sum_s[WIDTH];
        MODE_SAW_DN: boundary_s = (counter_r < step);
        default:     boundary_s = 1'b0;
      endcase
    end
  end

  // Register the strobe so that it lines up with the first sample of the
  // new period.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      wrap_pulse <= 1'b0;
    end else if (en) begin
      wrap_pulse <= boundary_s;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end
`else
  assign wrap_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wave_gen_multi.sv
// Directed self-checking bench for wave_gen_multi (WIDTH=8). The expected
// wrap_pulse values depend on whether WAVE_GEN_WRAP_PULSE_EN is defined.
module tb_wave_gen_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] step = 8'd0;
  logic [7:0] phase = 8'd0;
  wire  [7:0] dac_out;
  wire        dir;
  wire        wrap_pulse;

  int total = 0;
  int bad = 0;

`ifdef WAVE_GEN_WRAP_PULSE_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  wave_gen_multi #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .step       (step),
    .phase      (phase),
    .load       (load),
    .dac_out    (dac_out),
    .dir        (dir),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [7:0] s, input logic [7:0] p);
    reset = 1'b1; en = 1'b1; load = 1'b0; mode = m; step = s; phase = p;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b00, 8'd1, 8'd128);
    total++; if (dac_out !== 8'd128) begin bad++; $display("FAIL reset_dac: got %0d expected 128", dac_out); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL reset_dir: got %0b expected 1", dir); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b expected 0", wrap_pulse); end
    do_reset(2'b10, 8'd1, 8'd200);
    total++; if (dac_out !== 8'd255) begin bad++; $display("FAIL reset_square_dac: got %0d expected 255", dac_out); end
  endtask

  task automatic test_triangle_step1();
    logic [7:0] e;
    do_reset(2'b00, 8'd1, 8'd128);
    for (int i = 1; i <= 127; i++) begin
      tick();
      e = 8'(128 + i);
      total++; if (dac_out !== e) begin bad++; $display("FAIL tri1_dac cycle %0d: got %0d expected %0d", i, dac_out, e); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL tri1_dir cycle %0d: got %0b expected 1", i, dir); end
    end
    tick();
    total++; if (dac_out !== 8'd254) begin bad++; $display("FAIL tri1_turn_dac: got %0d expected 254", dac_out); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL tri1_turn_dir: got %0b expected 0", dir); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL tri1_turn_wrap: got %0b expected 0", wrap_pulse); end
  endtask

  task automatic test_triangle_step100();
    logic [7:0] exp_d [0:7];
    logic       exp_dir [0:7];
    logic       exp_w;
    exp_d   = '{8'd0, 8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
    exp_dir = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset(2'b00, 8'd100, 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      exp_w = WRAP_ON && (i == 7);
      total++; if (dac_out !== exp_d[i]) begin bad++; $display("FAIL tri100_dac idx %0d: got %0d expected %0d", i, dac_out, exp_d[i]); end
      total++; if (dir !== exp_dir[i]) begin bad++; $display("FAIL tri100_dir idx %0d: got %0b expected %0b", i, dir, exp_dir[i]); end
      total++; if (wrap_pulse !== exp_w) begin bad++; $display("FAIL tri100_wrap idx %0d: got %0b expected %0b", i, wrap_pulse, exp_w); end
    end
  endtask

  task automatic test_triangle_extremes();
    do_reset(2'b00, 8'd255, 8'd255);
    tick();
    total++; if (dac_out !== 8'd0) begin bad++; $display("FAIL trimax_floor_dac: got %0d expected 0", dac_out); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL trimax_floor_dir: got %0b expected 0", dir); end
    tick();
    total++; if (dac_out !== 8'd255) begin bad++; $display("FAIL trimax_ceil_dac: got %0d expected 255", dac_out); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL trimax_ceil_dir: got %0b expected 1", dir); end
    total++; if (wrap_pulse !== WRAP_ON) begin bad++; $display("FAIL trimax_ceil_wrap: got %0b expected %0b", wrap_pulse, WRAP_ON); end
  endtask

  task automatic test_saw_up();
    logic [7:0] exp_d [0:5];
    logic       exp_w;
    exp_d = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0, 8'd64};
    do_reset(2'b01, 8'd64, 8'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      exp_w = WRAP_ON && (i == 4);
      total++; if (dac_out !== exp_d[i]) begin bad++; $display("FAIL sawup_dac idx %0d: got %0d expected %0d", i, dac_out, exp_d[i]); end
      total++; if (wrap_pulse !== exp_w) begin bad++; $display("FAIL sawup_wrap idx %0d: got %0b expected %0b", i, wrap_pulse, exp_w); end
    end
  endtask

  task automatic test_square_and_saw_down();
    logic [7:0] exp_sq [0:3];
    logic [7:0] exp_sd [0:2];
    logic       exp_w;
    exp_sq = '{8'd0, 8'd255, 8'd0, 8'd255};
    exp_sd = '{8'd8, 8'd248, 8'd232};
    do_reset(2'b10, 8'd128, 8'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      exp_w = WRAP_ON && (i == 2);
      total++; if (dac_out !== exp_sq[i]) begin bad++; $display("FAIL square_dac idx %0d: got %0d expected %0d", i, dac_out, exp_sq[i]); end
      total++; if (wrap_pulse !== exp_w) begin bad++; $display("FAIL square_wrap idx %0d: got %0b expected %0b", i, wrap_pulse, exp_w); end
    end
    do_reset(2'b11, 8'd16, 8'd8);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      exp_w = WRAP_ON && (i == 1);
      total++; if (dac_out !== exp_sd[i]) begin bad++; $display("FAIL sawdn_dac idx %0d: got %0d expected %0d", i, dac_out, exp_sd[i]); end
      total++; if (wrap_pulse !== exp_w) begin bad++; $display("FAIL sawdn_wrap idx %0d: got %0b expected %0b", i, wrap_pulse, exp_w); end
    end
  endtask

  task automatic test_hold_load_reset();
    do_reset(2'b01, 8'd1, 8'd48);
    tick();
    tick();
    total++; if (dac_out !== 8'd50) begin bad++; $display("FAIL hold_start_dac: got %0d expected 50", dac_out); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dac_out !== 8'd50) begin bad++; $display("FAIL hold_dac cycle %0d: got %0d expected 50", i, dac_out); end
      total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL hold_wrap cycle %0d: got %0b expected 0", i, wrap_pulse); end
    end
    load = 1'b1; phase = 8'd200;
    tick();
    load = 1'b0;
    total++; if (dac_out !== 8'd200) begin bad++; $display("FAIL load_dac: got %0d expected 200", dac_out); end
    // Drive the triangle downward so the reset below must restore dir.
    en = 1'b1; mode = 2'b00; step = 8'd100;
    tick();
    tick();
    total++; if (dac_out !== 8'd155) begin bad++; $display("FAIL pre_reset_dac: got %0d expected 155", dac_out); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL pre_reset_dir: got %0b expected 0", dir); end
    reset = 1'b1; load = 1'b1; phase = 8'd7;
    tick();
    reset = 1'b0; load = 1'b0;
    total++; if (dac_out !== 8'd7) begin bad++; $display("FAIL reset_load_dac: got %0d expected 7", dac_out); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL reset_load_dir: got %0b expected 1", dir); end
  endtask

  task automatic test_mode_change_and_step_zero();
    do_reset(2'b01, 8'd5, 8'd10);
    tick();
    total++; if (dac_out !== 8'd15) begin bad++; $display("FAIL mc_sawup_dac: got %0d expected 15", dac_out); end
    mode = 2'b10;
    tick();
    total++; if (dac_out !== 8'd0) begin bad++; $display("FAIL mc_square_dac: got %0d expected 0", dac_out); end
    mode = 2'b11;
    tick();
    total++; if (dac_out !== 8'd15) begin bad++; $display("FAIL mc_sawdn_dac: got %0d expected 15", dac_out); end
    step = 8'd0;
    tick();
    total++; if (dac_out !== 8'd15) begin bad++; $display("FAIL step0_dac: got %0d expected 15", dac_out); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL step0_wrap: got %0b expected 0", wrap_pulse); end
    // Zero step at the triangle top must not turn around.
    do_reset(2'b00, 8'd0, 8'd255);
    tick();
    total++; if (dac_out !== 8'd255) begin bad++; $display("FAIL step0_top_dac: got %0d expected 255", dac_out); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL step0_top_dir: got %0b expected 1", dir); end
  endtask

  initial begin
    test_reset();
    test_triangle_step1();
    test_triangle_step100();
    test_triangle_extremes();
    test_saw_up();
    test_square_and_saw_down();
    test_hold_load_reset();
    test_mode_change_and_step_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
